// File: rtl/lcd_if_pkg.sv
// Shared types and command ROM for the ILI9341 SPI responder.
package lcd_if_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HW_RST_LO,
    ST_HW_RST_WAIT,
    ST_SEND_ROM,
    ST_DELAY,
    ST_STREAM,
    ST_FINISH
  } state_e;

  typedef struct packed {
    logic       is_cmd;
    logic       is_delay;
    logic [7:0] data;
  } rom_entry_t;

  localparam logic [4:0] INIT_START  = 5'd0;
  localparam logic [4:0] INIT_END    = 5'd6;
  localparam logic [4:0] PXCMD_START = 5'd7;
  localparam logic [4:0] PXCMD_END   = 5'd17;

  localparam logic [9:0] STREAM_BYTES = 10'd512;
  localparam logic [7:0] NOP_CMD      = 8'h00;
  localparam logic [7:0] RAMWR_CMD    = 8'h2C;

  // Full-frame window: columns 0..239 (0xEF), rows 0..319 (0x13F).
  function automatic rom_entry_t rom_lookup(input logic [4:0] idx);
    rom_entry_t e;
    case (idx)
      5'd0:    e = {1'b1, 1'b1, 8'h01};
      5'd1:    e = {1'b1, 1'b1, 8'h11};
      5'd2:    e = {1'b1, 1'b0, 8'h3A};
      5'd3:    e = {1'b0, 1'b0, 8'h55};
      5'd4:    e = {1'b1, 1'b0, 8'h36};
      5'd5:    e = {1'b0, 1'b0, 8'h48};
      5'd6:    e = {1'b1, 1'b0, 8'h29};
      5'd7:    e = {1'b1, 1'b0, 8'h2A};
      5'd8:    e = {1'b0, 1'b0, 8'h00};
      5'd9:    e = {1'b0, 1'b0, 8'h00};
      5'd10:   e = {1'b0, 1'b0, 8'h00};
      5'd11:   e = {1'b0, 1'b0, 8'hEF};
      5'd12:   e = {1'b1, 1'b0, 8'h2B};
      5'd13:   e = {1'b0, 1'b0, 8'h00};
      5'd14:   e = {1'b0, 1'b0, 8'h00};
      5'd15:   e = {1'b0, 1'b0, 8'h01};
      5'd16:   e = {1'b0, 1'b0, 8'h3F};
      5'd17:   e = {1'b1, 1'b0, RAMWR_CMD};
      default: e = '0;
    endcase
    return e;
  endfunction

endpackage

// File: rtl/lcd_spi_byte_tx.sv
// SPI mode-0 byte shifter: loads byte + dc on start, MSB first, done marks the final edge.
module lcd_spi_byte_tx
  import lcd_if_pkg::*;
#(
  parameter int unsigned HALF_PERIOD = 1
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       start_i,
  input  logic [7:0] data_i,
  input  logic       dc_i,
  output logic       sck_o,
  output logic       mosi_o,
  output logic       dc_o,
  output logic       done_o
);

  logic [7:0]  shreg_q;
  logic [2:0]  bit_q;
  logic        phase_q;
  logic [31:0] half_q;
  logic        busy_q;
  logic        sck_q;
  logic        mosi_q;
  logic        dc_q;

  assign sck_o  = sck_q;
  assign mosi_o = mosi_q;
  assign dc_o   = dc_q;
  // High during the last cycle of a byte, so the next start can land one idle cycle later.
  assign done_o = busy_q && phase_q && (bit_q == 3'd0) && (half_q == 32'd0);

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      shreg_q <= '0;
      bit_q   <= '0;
      phase_q <= 1'b0;
      half_q  <= '0;
      busy_q  <= 1'b0;
      sck_q   <= 1'b0;
      mosi_q  <= 1'b0;
      dc_q    <= 1'b0;
    end else if (busy_q) begin
      if (half_q != 32'd0) begin
        half_q <= half_q - 32'd1;
      end else begin
        half_q <= HALF_PERIOD - 1;
        if (!phase_q) begin
          sck_q   <= 1'b1;
          phase_q <= 1'b1;
        end else begin
          sck_q   <= 1'b0;
          phase_q <= 1'b0;
          if (bit_q == 3'd0) begin
            busy_q <= 1'b0;
            mosi_q <= 1'b0;
          end else begin
            bit_q   <= bit_q - 3'd1;
            shreg_q <= {shreg_q[6:0], 1'b0};
            mosi_q  <= shreg_q[6];
          end
        end
      end
    end else if (start_i) begin
      shreg_q <= data_i;
      mosi_q  <= data_i[7];
      dc_q    <= dc_i;
      bit_q   <= 3'd7;
      phase_q <= 1'b0;
      half_q  <= HALF_PERIOD - 1;
      busy_q  <= 1'b1;
    end
  end

endmodule

// File: rtl/lcd_spi_if.sv
// LCD begin/busy responder: panel init, window setup and 512-byte pixel streaming over SPI.
// Build option LCD_STREAM_BYTE_SWAP_EN swaps each stream byte pair on the wire.
module lcd_spi_if
  import lcd_if_pkg::*;
#(
  parameter int unsigned HALF_PERIOD     = 1,
  parameter int unsigned RST_LOW_CYC     = 40000,
  parameter int unsigned RST_WAIT_CYC    = 480000,
  parameter int unsigned SLPOUT_WAIT_CYC = 20000
) (
  input  logic       clk_4M,
  input  logic       rst_n,
  input  logic       if_init,
  input  logic       if_send_px_cmd,
  input  logic       if_stream,
  input  logic       if_end_of_frame,
  input  logic       if_begin,
  output logic       if_busy,
  input  logic [7:0] px_byte,
  input  logic       px_valid,
  output logic       px_ready,
  output logic       lcd_sck,
  output logic       lcd_mosi,
  output logic       lcd_cs_n,
  output logic       lcd_dc,
  output logic       lcd_rst_n
);

  state_e      state_q;
  logic        armed_q, eof_q, busy_q, cs_n_q, lcd_rst_q, px_ready_q;
  logic        tx_start_q, tx_dc_q, inflight_q, nop_q;
  logic [7:0]  tx_data_q;
  logic [4:0]  rom_idx_q, rom_end_q;
  logic [31:0] timer_q;
  logic [9:0]  cnt_q;
`ifdef LCD_STREAM_BYTE_SWAP_EN
  logic        swap_pend_q;
  logic [7:0]  hold_q;
`endif

  rom_entry_t  rom_cur;
  logic        accept, accept_tx, tx_start, tx_dc, tx_done, rom_last;
  logic [7:0]  tx_data;

  assign rom_cur  = rom_lookup(rom_idx_q);
  assign rom_last = (rom_idx_q == rom_end_q);
  assign accept   = px_ready_q && px_valid;
`ifdef LCD_STREAM_BYTE_SWAP_EN
  assign accept_tx = accept && cnt_q[0];
`else
  assign accept_tx = accept;
`endif
  // Accepted pixel bytes go straight into the shifter to keep a single idle cycle between bytes.
  assign tx_start = tx_start_q | accept_tx;

  always_comb begin
    tx_data = tx_data_q;
    tx_dc   = tx_dc_q;
    if (accept_tx) begin
      tx_data = px_byte;
      tx_dc   = 1'b1;
    end else if (state_q == ST_SEND_ROM) begin
      tx_data = rom_cur.data;
      tx_dc   = ~rom_cur.is_cmd;
    end
  end

  lcd_spi_byte_tx #(.HALF_PERIOD(HALF_PERIOD)) u_tx (
    .clk_i   (clk_4M),
    .rst_ni  (rst_n),
    .start_i (tx_start),
    .data_i  (tx_data),
    .dc_i    (tx_dc),
    .sck_o   (lcd_sck),
    .mosi_o  (lcd_mosi),
    .dc_o    (lcd_dc),
    .done_o  (tx_done)
  );

  assign if_busy   = busy_q;
  assign px_ready  = px_ready_q;
  assign lcd_cs_n  = cs_n_q;
  assign lcd_rst_n = lcd_rst_q;

  always_ff @(posedge clk_4M) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;    armed_q <= 1'b1;   eof_q <= 1'b0;
      busy_q <= 1'b0;        cs_n_q <= 1'b1;    lcd_rst_q <= 1'b1;
      px_ready_q <= 1'b0;    tx_start_q <= 1'b0; tx_dc_q <= 1'b0;
      tx_data_q <= '0;       rom_idx_q <= '0;   rom_end_q <= '0;
      timer_q <= '0;         cnt_q <= '0;       inflight_q <= 1'b0;
      nop_q <= 1'b0;
`ifdef LCD_STREAM_BYTE_SWAP_EN
      swap_pend_q <= 1'b0;   hold_q <= '0;
`endif
    end else begin
      tx_start_q <= 1'b0;
      if (!if_begin) armed_q <= 1'b1;
      case (state_q)
        ST_IDLE: if (armed_q && if_begin) begin
          armed_q <= 1'b0;
          busy_q  <= 1'b1;
          eof_q   <= if_end_of_frame;
          if (if_init) begin
            state_q   <= ST_HW_RST_LO;
            lcd_rst_q <= 1'b0;
            timer_q   <= RST_LOW_CYC - 1;
          end else if (if_send_px_cmd) begin
            state_q    <= ST_SEND_ROM;
            cs_n_q     <= 1'b0;
            rom_idx_q  <= PXCMD_START;
            rom_end_q  <= PXCMD_END;
            tx_start_q <= 1'b1;
          end else if (if_stream) begin
            state_q    <= ST_STREAM;
            cs_n_q     <= 1'b0;
            cnt_q      <= '0;
            px_ready_q <= 1'b1;
            inflight_q <= 1'b0;
            nop_q      <= 1'b0;
`ifdef LCD_STREAM_BYTE_SWAP_EN
            swap_pend_q <= 1'b0;
`endif
          end else begin
            state_q <= ST_FINISH;
          end
        end
        ST_HW_RST_LO: begin
          if (timer_q == 32'd0) begin
            state_q   <= ST_HW_RST_WAIT;
            lcd_rst_q <= 1'b1;
            timer_q   <= RST_WAIT_CYC - 1;
          end else timer_q <= timer_q - 32'd1;
        end
        ST_HW_RST_WAIT: begin
          if (timer_q == 32'd0) begin
            state_q    <= ST_SEND_ROM;
            cs_n_q     <= 1'b0;
            rom_idx_q  <= INIT_START;
            rom_end_q  <= INIT_END;
            tx_start_q <= 1'b1;
          end else timer_q <= timer_q - 32'd1;
        end
        ST_SEND_ROM: if (tx_done) begin
          if (rom_cur.is_delay) begin
            state_q <= ST_DELAY;
            timer_q <= SLPOUT_WAIT_CYC - 1;
          end else if (rom_last) begin
            state_q <= ST_FINISH;
            cs_n_q  <= 1'b1;
          end else begin
            rom_idx_q  <= rom_idx_q + 5'd1;
            tx_start_q <= 1'b1;
          end
        end
        ST_DELAY: begin
          if (timer_q != 32'd0) begin
            timer_q <= timer_q - 32'd1;
          end else if (rom_last) begin
            state_q <= ST_FINISH;
            cs_n_q  <= 1'b1;
          end else begin
            state_q    <= ST_SEND_ROM;
            rom_idx_q  <= rom_idx_q + 5'd1;
            tx_start_q <= 1'b1;
          end
        end
        ST_STREAM: begin
          if (accept) begin
            px_ready_q <= 1'b0;
            cnt_q      <= cnt_q + 10'd1;
`ifdef LCD_STREAM_BYTE_SWAP_EN
            if (!cnt_q[0]) hold_q <= px_byte;
            else begin
              inflight_q  <= 1'b1;
              swap_pend_q <= 1'b1;
            end
`else
            inflight_q <= 1'b1;
`endif
          end else if (inflight_q) begin
            if (tx_done) begin
              if (nop_q) begin
                state_q    <= ST_FINISH;
                cs_n_q     <= 1'b1;
                inflight_q <= 1'b0;
              end
`ifdef LCD_STREAM_BYTE_SWAP_EN
              else if (swap_pend_q) begin
                swap_pend_q <= 1'b0;
                tx_start_q  <= 1'b1;
                tx_data_q   <= hold_q;
                tx_dc_q     <= 1'b1;
              end
`endif
              else if (cnt_q == STREAM_BYTES) begin
                if (eof_q) begin
                  nop_q      <= 1'b1;
                  tx_start_q <= 1'b1;
                  tx_data_q  <= NOP_CMD;
                  tx_dc_q    <= 1'b0;
                end else begin
                  state_q    <= ST_FINISH;
                  cs_n_q     <= 1'b1;
                  inflight_q <= 1'b0;
                end
              end else begin
                inflight_q <= 1'b0;
                px_ready_q <= 1'b1;
              end
            end
          end else if (cnt_q != STREAM_BYTES) begin
            px_ready_q <= 1'b1;
          end
        end
        ST_FINISH: begin
          busy_q     <= 1'b0;
          px_ready_q <= 1'b0;
          state_q    <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lcd_spi_if.sv
// Scoreboard bench for lcd_spi_if: expected SPI bytes queued at stimulus time, popped by a wire monitor.
module tb_lcd_spi_if;

  localparam int unsigned HP  = 1;
  localparam int unsigned RLC = 20;
  localparam int unsigned RWC = 30;
  localparam int unsigned SWC = 10;

  logic clk_4M = 1'b0;
  logic rst_n = 1'b0;
  logic if_init = 1'b0, if_send_px_cmd = 1'b0, if_stream = 1'b0;
  logic if_end_of_frame = 1'b0, if_begin = 1'b0;
  logic [7:0] px_byte = 8'h00;
  logic px_valid = 1'b0;
  logic if_busy, px_ready, lcd_sck, lcd_mosi, lcd_cs_n, lcd_dc, lcd_rst_n;

  int checks = 0;
  int errors = 0;
  logic [8:0] exp_q[$];
  int bytes_rx = 0;
  int rst_lo_cnt = 0;
  int busy_hi_cnt = 0;

  always #5 clk_4M = ~clk_4M;

  lcd_spi_if #(
    .HALF_PERIOD(HP), .RST_LOW_CYC(RLC), .RST_WAIT_CYC(RWC), .SLPOUT_WAIT_CYC(SWC)
  ) dut (
    .clk_4M(clk_4M), .rst_n(rst_n), .if_init(if_init), .if_send_px_cmd(if_send_px_cmd),
    .if_stream(if_stream), .if_end_of_frame(if_end_of_frame), .if_begin(if_begin),
    .if_busy(if_busy), .px_byte(px_byte), .px_valid(px_valid), .px_ready(px_ready),
    .lcd_sck(lcd_sck), .lcd_mosi(lcd_mosi), .lcd_cs_n(lcd_cs_n), .lcd_dc(lcd_dc),
    .lcd_rst_n(lcd_rst_n)
  );

  // SPI wire monitor: bits on SCK rising, dc captured on the first bit and must hold.
  logic sck_prev = 1'b0;
  int bitc = 0;
  logic [7:0] sh = 8'h00;
  logic dc_cap = 1'b0;
  logic dc_chg = 1'b0;
  logic [8:0] exp_b;
  always @(negedge clk_4M) begin
    if (lcd_cs_n || !rst_n) begin
      bitc = 0;
    end else if (lcd_sck && !sck_prev) begin
      sh = {sh[6:0], lcd_mosi};
      if (bitc == 0) begin
        dc_cap = lcd_dc;
        dc_chg = 1'b0;
      end else if (lcd_dc !== dc_cap) begin
        dc_chg = 1'b1;
      end
      bitc++;
      if (bitc == 8) begin
        bitc = 0;
        bytes_rx++;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL spi_unexpected: got dc=%0b data=%02h, none expected", dc_cap, sh);
        end else begin
          exp_b = exp_q.pop_front();
          if ({dc_cap, sh} !== exp_b || dc_chg) begin
            errors++;
            $display("FAIL spi_byte: got dc=%0b data=%02h (dc_changed=%0b), exp dc=%0b data=%02h",
                     dc_cap, sh, dc_chg, exp_b[8], exp_b[7:0]);
          end
        end
      end
    end
    sck_prev = lcd_sck;
  end

  always @(negedge clk_4M) begin
    if (!lcd_rst_n) rst_lo_cnt++;
    if (if_busy) busy_hi_cnt++;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic start_op(input logic i, input logic p, input logic s, input logic e,
                          input logic hold);
    bit ok;
    ok = 0;
    @(posedge clk_4M); #1;
    if_init = i; if_send_px_cmd = p; if_stream = s; if_end_of_frame = e; if_begin = 1'b1;
    for (int t = 0; t < 10 && !ok; t++) begin
      @(negedge clk_4M);
      if (if_busy) ok = 1;
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL busy_rise: busy=%0b, required 1 within 10 cycles", if_busy);
    end
    @(posedge clk_4M); #1;
    if (!hold) begin
      if_begin = 1'b0;
      if_init = 1'b0; if_send_px_cmd = 1'b0; if_stream = 1'b0; if_end_of_frame = 1'b0;
    end
  endtask

  task automatic wait_done(input int limit, output bit cs_ok);
    bit done, prev_busy, prev_cs;
    done = 0; prev_busy = 1; prev_cs = 0; cs_ok = 0;
    for (int t = 0; t < limit && !done; t++) begin
      @(negedge clk_4M);
      if (!if_busy) begin
        done  = 1;
        cs_ok = prev_busy && prev_cs && lcd_cs_n;
      end
      prev_busy = if_busy;
      prev_cs   = lcd_cs_n;
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL busy_fall: busy still %0b after %0d cycles", if_busy, limit);
    end
  endtask

  task automatic send_px(input logic [7:0] b, output bit ok);
    ok = 0;
    px_byte = b;
    px_valid = 1'b1;
    for (int t = 0; t < 200 && !ok; t++) begin
      @(negedge clk_4M);
      if (px_ready) ok = 1;
      @(posedge clk_4M); #1;
    end
    px_valid = 1'b0;
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL px_accept: px_ready=%0b, required 1 within 200 cycles", px_ready);
    end
  endtask

  // Drives n source bytes (i mod 256) with random gaps; expected wire order queued on accept.
  task automatic drive_stream(input int n);
    bit ok;
    logic [7:0] b, held;
    held = 8'h00;
    for (int i = 0; i < n; i++) begin
      b = i[7:0];
      if (i % 64 == 32) begin
        repeat (40) begin @(posedge clk_4M); #1; end
        @(negedge clk_4M);
        checks++;
        if (lcd_sck !== 1'b0 || lcd_cs_n !== 1'b0 || if_busy !== 1'b1) begin
          errors++;
          $display("FAIL gap_idle: sck=%0b cs_n=%0b busy=%0b, required 0 0 1",
                   lcd_sck, lcd_cs_n, if_busy);
        end
        @(posedge clk_4M); #1;
      end else begin
        repeat ($urandom_range(0, 3)) begin @(posedge clk_4M); #1; end
      end
      send_px(b, ok);
      if (!ok) break;
`ifdef LCD_STREAM_BYTE_SWAP_EN
      if (i % 2 == 0) held = b;
      else begin
        exp_q.push_back({1'b1, b});
        exp_q.push_back({1'b1, held});
      end
`else
      exp_q.push_back({1'b1, b});
`endif
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(posedge clk_4M);
    @(negedge clk_4M);
    checks++;
    if ({if_busy, px_ready, lcd_sck, lcd_mosi, lcd_cs_n, lcd_dc, lcd_rst_n} !== 7'b0000101) begin
      errors++;
      $display("FAIL reset_vals: got %07b, required 0000101",
               {if_busy, px_ready, lcd_sck, lcd_mosi, lcd_cs_n, lcd_dc, lcd_rst_n});
    end
    @(posedge clk_4M); #1;
    rst_n = 1'b1;
    repeat (5) @(posedge clk_4M);
    @(negedge clk_4M);
    checks++;
    if ({if_busy, px_ready, lcd_sck, lcd_cs_n, lcd_rst_n} !== 5'b00011) begin
      errors++;
      $display("FAIL idle_vals: got %05b, required 00011",
               {if_busy, px_ready, lcd_sck, lcd_cs_n, lcd_rst_n});
    end
  endtask

  task automatic test_init;
    int b0;
    bit cs_ok;
    exp_q.push_back({1'b0, 8'h01}); exp_q.push_back({1'b0, 8'h11});
    exp_q.push_back({1'b0, 8'h3A}); exp_q.push_back({1'b1, 8'h55});
    exp_q.push_back({1'b0, 8'h36}); exp_q.push_back({1'b1, 8'h48});
    exp_q.push_back({1'b0, 8'h29});
    b0 = bytes_rx;
    rst_lo_cnt = 0;
    start_op(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    wait_done(2000, cs_ok);
    checks++;
    if (rst_lo_cnt != RLC) begin
      errors++;
      $display("FAIL init_rst_low: got %0d cycles, required %0d", rst_lo_cnt, RLC);
    end
    checks++;
    if (bytes_rx - b0 != 7 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL init_bytes: got %0d bytes (%0d left), required 7 (0)",
               bytes_rx - b0, exp_q.size());
    end
    checks++;
    if (!cs_ok) begin
      errors++;
      $display("FAIL init_cs_before_busy: cs_ok=%0b, required 1", cs_ok);
    end
  endtask

  task automatic push_pxcmd;
    exp_q.push_back({1'b0, 8'h2A}); exp_q.push_back({1'b1, 8'h00});
    exp_q.push_back({1'b1, 8'h00}); exp_q.push_back({1'b1, 8'h00});
    exp_q.push_back({1'b1, 8'hEF}); exp_q.push_back({1'b0, 8'h2B});
    exp_q.push_back({1'b1, 8'h00}); exp_q.push_back({1'b1, 8'h00});
    exp_q.push_back({1'b1, 8'h01}); exp_q.push_back({1'b1, 8'h3F});
    exp_q.push_back({1'b0, 8'h2C});
  endtask

  task automatic test_px_cmd;
    int b0;
    bit cs_ok;
    push_pxcmd();
    b0 = bytes_rx;
    rst_lo_cnt = 0;
    start_op(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    wait_done(1000, cs_ok);
    checks++;
    if (bytes_rx - b0 != 11 || exp_q.size() != 0 || rst_lo_cnt != 0 || !cs_ok) begin
      errors++;
      $display("FAIL pxcmd: bytes=%0d left=%0d rst_lo=%0d cs_ok=%0b, required 11 0 0 1",
               bytes_rx - b0, exp_q.size(), rst_lo_cnt, cs_ok);
    end
  endtask

  task automatic test_priority;
    int b0;
    bit cs_ok;
    push_pxcmd();
    b0 = bytes_rx;
    start_op(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    wait_done(1000, cs_ok);
    checks++;
    if (bytes_rx - b0 != 11 || exp_q.size() != 0 || px_ready !== 1'b0) begin
      errors++;
      $display("FAIL priority: bytes=%0d left=%0d px_ready=%0b, required 11 0 0",
               bytes_rx - b0, exp_q.size(), px_ready);
    end
  endtask

  task automatic test_noop;
    int b0;
    bit cs_ok;
    b0 = bytes_rx;
    busy_hi_cnt = 0;
    start_op(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    wait_done(20, cs_ok);
    repeat (10) @(negedge clk_4M);
    checks++;
    if (busy_hi_cnt != 1 || bytes_rx != b0 || lcd_cs_n !== 1'b1) begin
      errors++;
      $display("FAIL noop: busy_cycles=%0d bytes=%0d cs_n=%0b, required 1 0 1",
               busy_hi_cnt, bytes_rx - b0, lcd_cs_n);
    end
  endtask

  task automatic test_stream(input logic eof);
    int b0;
    bit cs_ok;
    b0 = bytes_rx;
    start_op(1'b0, 1'b0, 1'b1, eof, 1'b0);
    drive_stream(512);
    if (eof) exp_q.push_back({1'b0, 8'h00});
    wait_done(5000, cs_ok);
    checks++;
    if (bytes_rx - b0 != 512 + int'(eof) || exp_q.size() != 0 || !cs_ok) begin
      errors++;
      $display("FAIL stream_eof%0b: bytes=%0d left=%0d cs_ok=%0b, required %0d 0 1",
               eof, bytes_rx - b0, exp_q.size(), cs_ok, 512 + int'(eof));
    end
  endtask

  task automatic test_begin_held;
    int b0;
    bit cs_ok;
    push_pxcmd();
    b0 = bytes_rx;
    start_op(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    wait_done(1000, cs_ok);
    busy_hi_cnt = 0;
    repeat (60) @(negedge clk_4M);
    checks++;
    if (busy_hi_cnt != 0 || bytes_rx - b0 != 11 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL begin_held: extra busy=%0d bytes=%0d left=%0d, required 0 11 0",
               busy_hi_cnt, bytes_rx - b0, exp_q.size());
    end
    @(posedge clk_4M); #1;
    if_begin = 1'b0; if_send_px_cmd = 1'b0;
    repeat (3) @(posedge clk_4M);
    #1;
  endtask

  task automatic test_mid_reset;
    int b0, exp_bytes, exp_left;
`ifdef LCD_STREAM_BYTE_SWAP_EN
    exp_bytes = 98; exp_left = 2;
`else
    exp_bytes = 99; exp_left = 1;
`endif
    b0 = bytes_rx;
    start_op(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    drive_stream(100);
    repeat (5) @(posedge clk_4M);
    #1;
    rst_n = 1'b0;
    @(posedge clk_4M); #1;
    checks++;
    if (lcd_cs_n !== 1'b1 || lcd_sck !== 1'b0 || if_busy !== 1'b0 || px_ready !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset: cs_n=%0b sck=%0b busy=%0b ready=%0b, required 1 0 0 0",
               lcd_cs_n, lcd_sck, if_busy, px_ready);
    end
    checks++;
    if (bytes_rx - b0 != exp_bytes || exp_q.size() != exp_left) begin
      errors++;
      $display("FAIL mid_reset_bytes: sent=%0d pending=%0d, required %0d %0d",
               bytes_rx - b0, exp_q.size(), exp_bytes, exp_left);
    end
    exp_q.delete();
    repeat (2) @(posedge clk_4M);
    #1;
    rst_n = 1'b1;
    repeat (3) @(posedge clk_4M);
    #1;
  endtask

  initial begin
    test_reset();
    test_init();
    test_px_cmd();
    test_priority();
    test_noop();
    test_stream(1'b0);
    test_stream(1'b1);
    test_begin_held();
    test_mid_reset();
    test_stream(1'b0);
    repeat (5) @(posedge clk_4M);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
